bitstream_fetcher: RTL

//  Consumer end of the byte-source handshake (request / data / data_ready) that feeds the arithmetic decoder.

---
 rtl/bitstream_fetcher.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/bitstream_fetcher.sv
// -----------------------------------------------------------------------------
// bitstream_fetcher
//   Consumer end of the byte-source handshake that feeds the arithmetic
//   decoder. Bytes are pulled on demand into an MSB-first bit buffer, and
//   reads of 0..16 bits are served to the decoder. The decoder never sees
//   byte boundaries.
//
//   Buffer invariant: the valid bits occupy the top level_r bits of buf_r,
//   and every bit below them is zero. That invariant is what lets an
//   over-read at end of stream return zeros for the missing bits.
//
// Ports
//   clk           clock, all state on posedge
//   rst_n         asynchronous active-low reset
//   byte_request  consume byte_data at this posedge (combinational)
//   byte_data     current byte from the source
//   byte_ready    source holds a valid byte; a 0 after the first byte = end
//   rd_valid      decoder requests rd_num bits
//   rd_num        bits requested, 0..16 (larger values clamp to 16)
//   rd_ready      read can be granted this cycle (combinational)
//   rd_data       registered read result, right-aligned, upper bits zero
//   rd_done       one-cycle pulse, rd_data valid
//   rd_align      drop (level mod 8) bits to byte-align; ignored when rd_valid=1
//   eos           stream ended and buffer empty (registered)
//   bits_consumed running count of bits handed out or discarded (wraps)
//
// Configuration
//   BITFETCH_ZERO_PAD_EN : once the stream has ended, every read is granted;
//                          missing bits read as 0 and the level saturates at 0.
//                          When undefined, a read stalls while n > level.
// -----------------------------------------------------------------------------
module bitstream_fetcher #(
    parameter int BUF_W     = 32,
    parameter int MAX_RD    = 16,
    parameter int REFILL_LE = BUF_W - 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        byte_request,
    input  logic [7:0]  byte_data,
    input  logic        byte_ready,
    input  logic        rd_valid,
    input  logic [4:0]  rd_num,
    output logic        rd_ready,
    output logic [15:0] rd_data,
    output logic        rd_done,
    input  logic        rd_align,
    output logic        eos,
    output logic [31:0] bits_consumed
);

    localparam int LVL_W = $clog2(BUF_W + 1);
    localparam int RD_W  = 16;

    logic [BUF_W-1:0] buf_r;
    logic [LVL_W-1:0] level_r;
    logic             ended_r;
    logic             got_byte_r;
    logic             eos_r;
    logic             rd_done_r;
    logic [RD_W-1:0]  rd_data_r;
    logic [31:0]      bits_r;

    logic [4:0]       n_s;
    logic [LVL_W-1:0] n_lvl_s;
    logic             take_s;
    logic             grant_s;
    logic             align_s;
    logic [LVL_W-1:0] drop_s;
    logic [BUF_W-1:0] rem_s;
    logic [LVL_W-1:0] rem_level_s;
    logic [BUF_W-1:0] buf_next_s;
    logic [LVL_W-1:0] level_next_s;
    logic             ended_next_s;
    logic [RD_W-1:0]  top_s;
    logic [RD_W-1:0]  rd_bits_s;
    logic [31:0]      bits_add_s;

    // Clamp the request size, derive handshakes and read readiness.
    always_comb begin
        n_s          = rd_num;
        n_lvl_s      = '0;
        byte_request = 1'b0;
        rd_ready     = 1'b0;
        if (rd_num > 5'(MAX_RD)) begin
            n_s = 5'(MAX_RD);
        end else begin
            n_s = rd_num;
        end
        n_lvl_s      = {{(LVL_W-5){1'b0}}, n_s};
        byte_request = rst_n & byte_ready & (level_r <= LVL_W'(REFILL_LE));
`ifdef BITFETCH_ZERO_PAD_EN
        rd_ready     = ended_r | (level_r >= n_lvl_s);
`else
        rd_ready     = (level_r >= n_lvl_s);
`endif
    end

    assign take_s  = byte_request;
    assign grant_s = rd_valid & rd_ready;
    assign align_s = rd_align & ~rd_valid;

    // Work out how many bits leave the top of the buffer this cycle.
    always_comb begin
        drop_s     = '0;
        bits_add_s = 32'd0;
        if (grant_s) begin
            drop_s     = n_lvl_s;
            bits_add_s = {27'd0, n_s};
        end else if (align_s) begin
            drop_s     = {{(LVL_W-3){1'b0}}, level_r[2:0]};
            bits_add_s = {29'd0, level_r[2:0]};
        end else begin
            drop_s     = '0;
            bits_add_s = 32'd0;
        end
    end

    // Consume from the top, then land any incoming byte just below the remainder.
    always_comb begin
        rem_s        = buf_r << drop_s;
        rem_level_s  = '0;
        buf_next_s   = '0;
        level_next_s = '0;
        // Over-read only happens in zero-pad mode; the level floors at zero.
        if (drop_s > level_r) begin
            rem_level_s = '0;
        end else begin
            rem_level_s = level_r - drop_s;
        end
        if (take_s) begin
            buf_next_s   = rem_s | ({byte_data, {(BUF_W-8){1'b0}}} >> rem_level_s);
            level_next_s = rem_level_s + LVL_W'(8);
        end else begin
            buf_next_s   = rem_s;
            level_next_s = rem_level_s;
        end
        ended_next_s = ended_r | (got_byte_r & ~byte_ready);
    end

    // Right-align the top n buffer bits as the read result.
    always_comb begin
        top_s     = buf_r[BUF_W-1 -: RD_W];
        rd_bits_s = '0;
        if (n_s == 5'd0) begin
            rd_bits_s = '0;
        end else begin
            rd_bits_s = top_s >> (5'(RD_W) - n_s);
        end
    end

    // State registers: buffer, level, end tracking and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_r      <= '0;
            level_r    <= '0;
            ended_r    <= 1'b0;
            got_byte_r <= 1'b0;
            eos_r      <= 1'b0;
            rd_done_r  <= 1'b0;
            rd_data_r  <= '0;
            bits_r     <= 32'd0;
        end else begin
            buf_r      <= buf_next_s;
            level_r    <= level_next_s;
            ended_r    <= ended_next_s;
            got_byte_r <= got_byte_r | take_s;
            eos_r      <= ended_next_s & (level_next_s == '0);
            rd_done_r  <= grant_s;
            bits_r     <= bits_r + bits_add_s;
            if (grant_s) begin
                rd_data_r <= rd_bits_s;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign rd_data       = rd_data_r;
    assign rd_done       = rd_done_r;
    assign eos           = eos_r;
    assign bits_consumed = bits_r;

endmodule
